i2s_tx_sequencer: RTL and testbench

Controller that schedules stereo PCM samples onto an I2S serial link clocked from scki. It accepts left/right sample pairs over a valid/ready handshake into a one-entry holding buffer. It derives bck by integer division of scki, generates lrck, and shifts each word MSB-first with the standard I2S one-bit delay. It sits between a sample source (sine LUT generator, DSP chain) and the DAC/ADC pins, replacing ad-hoc per-source I2S timing.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_tx_sequencer_bit_timer.sv | 68 ++++++
 rtl/i2s_tx_sequencer.sv | 150 +++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sequencer.
package i2s_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StStop = 2'd2
   } state_e;

   localparam int unsigned DefWidth  = 24;
   localparam int unsigned DefSlot   = 32;
   localparam int unsigned DefBckDiv = 4;

   // Bits needed for a counter spanning 0..n-1; never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2s_tx_sequencer_bit_timer.sv
// Bit-clock divider and frame bit counter: produces bck, lrck and the frame boundary strobe.
module i2s_bit_timer
   import i2s_pkg::*;
#(
   parameter int unsigned SLOT    = DefSlot,
   parameter int unsigned BCK_DIV = DefBckDiv,
   localparam int unsigned BitW   = cnt_width(2 * SLOT)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            run_i,
   output logic            bck_o,
   output logic            lrck_o,
   output logic            boundary_o,
   output logic [BitW-1:0] bit_nxt_o
);

   localparam int unsigned DivW = cnt_width(BCK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(BCK_DIV - 1);
   localparam logic [DivW-1:0] DivHalf = DivW'(BCK_DIV / 2);
   localparam logic [BitW-1:0] BitLast = BitW'(2 * SLOT - 1);
   localparam logic [BitW-1:0] SlotLen = BitW'(SLOT);

   logic [DivW-1:0] div_ctr_d, div_ctr_q;
   logic [BitW-1:0] bit_ctr_d, bit_ctr_q;
   logic            bck_d, bck_q;
   logic            lrck_d, lrck_q;
   logic            tick;

   // tick is the last scki cycle of a bck period, i.e. the cycle before bck falls
   assign tick       = run_i && (div_ctr_q == DivLast);
   assign boundary_o = tick && (bit_ctr_q == BitLast);
   assign bit_nxt_o  = bit_ctr_d;
   assign bck_o      = bck_q;
   assign lrck_o     = lrck_q;

   // Advance divider every cycle and bit counter on tick; park both at zero when not running.
   always_comb begin
      div_ctr_d = '0;
      bit_ctr_d = '0;
      if (run_i) begin
         div_ctr_d = tick ? '0 : div_ctr_q + 1'b1;
         bit_ctr_d = bit_ctr_q;
         if (tick) begin
            bit_ctr_d = (bit_ctr_q == BitLast) ? '0 : bit_ctr_q + 1'b1;
         end
      end
      // Registered so bck/lrck line up with the counter values they are decoded from
      bck_d  = (div_ctr_d >= DivHalf);
      lrck_d = (bit_ctr_d >= SlotLen);
   end

   // Counter and bit-clock state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_ctr_q <= '0;
         bit_ctr_q <= '0;
         bck_q     <= 1'b0;
         lrck_q    <= 1'b0;
      end else begin
         div_ctr_q <= div_ctr_d;
         bit_ctr_q <= bit_ctr_d;
         bck_q     <= bck_d;
         lrck_q    <= lrck_d;
      end
   end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: sample handshake, one-entry holding buffer, run/stop FSM and serializer.
module i2s_tx_sequencer
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned SLOT    = DefSlot,
   parameter int unsigned BCK_DIV = DefBckDiv
) (
   input  logic             scki,
   input  logic             rst,
   input  logic             enable,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_left,
   input  logic [WIDTH-1:0] s_right,
   output logic             bck,
   output logic             lrck,
   output logic             sdata,
   output logic             frame_start,
   output logic             underrun
);

   localparam int unsigned BitW = cnt_width(2 * SLOT);
   localparam int unsigned IdxW = cnt_width(WIDTH);
   localparam logic [BitW-1:0] SlotLen = BitW'(SLOT);
   localparam logic [BitW-1:0] WordLen = BitW'(WIDTH);

   state_e           state_d, state_q;
   logic             hold_full_d, hold_full_q;
   logic [WIDTH-1:0] hold_left_d, hold_left_q;
   logic [WIDTH-1:0] hold_right_d, hold_right_q;
   logic [WIDTH-1:0] word_left_d, word_left_q;
   logic [WIDTH-1:0] word_right_d, word_right_q;
   logic             sdata_d, sdata_q;
   logic             frame_start_d, frame_start_q;
   logic             underrun_d, underrun_q;

   logic             accept;
   logic             load;
   logic             boundary;
   logic [BitW-1:0]  bit_nxt;
   logic [BitW-1:0]  half_bit;
   logic [WIDTH-1:0] cur_word;
   logic [IdxW-1:0]  bit_idx;

   i2s_bit_timer #(
      .SLOT    (SLOT),
      .BCK_DIV (BCK_DIV)
   ) u_bit_timer (
      .clk_i      (scki),
      .rst_i      (rst),
      .run_i      (state_q != StIdle),
      .bck_o      (bck),
      .lrck_o     (lrck),
      .boundary_o (boundary),
      .bit_nxt_o  (bit_nxt)
   );

   assign s_ready     = ~hold_full_q;
   assign accept      = s_valid && ~hold_full_q;
   assign sdata       = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

   // Run/stop sequencing and the decision to load a new frame.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StRun;
               load    = 1'b1;
            end
         end
         StRun: begin
            if (!enable) state_d = StStop;
            load = boundary;
         end
         StStop: begin
            // Re-enable before the boundary resumes seamlessly; otherwise drain to idle
            if (enable) begin
               state_d = StRun;
               load    = boundary;
            end else if (boundary) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Holding buffer and frame load; a pair accepted on the load cycle waits for the next frame.
   always_comb begin
      hold_full_d   = hold_full_q;
      hold_left_d   = hold_left_q;
      hold_right_d  = hold_right_q;
      word_left_d   = word_left_q;
      word_right_d  = word_right_q;
      frame_start_d = load;
      underrun_d    = load && !hold_full_q;
      if (load) begin
         word_left_d  = hold_full_q ? hold_left_q : '0;
         word_right_d = hold_full_q ? hold_right_q : '0;
         hold_full_d  = 1'b0;
      end
      if (accept) begin
         hold_full_d  = 1'b1;
         hold_left_d  = s_left;
         hold_right_d = s_right;
      end
   end

   // Serializer: bit for the upcoming slot, MSB one bck after the lrck edge, zero padding after.
   always_comb begin
      half_bit = (bit_nxt >= SlotLen) ? bit_nxt - SlotLen : bit_nxt;
      cur_word = (bit_nxt >= SlotLen) ? word_right_d : word_left_d;
      bit_idx  = IdxW'(WordLen - half_bit);
      sdata_d  = 1'b0;
      if ((half_bit != '0) && (half_bit <= WordLen)) begin
         sdata_d = cur_word[bit_idx];
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge scki or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         hold_full_q   <= 1'b0;
         hold_left_q   <= '0;
         hold_right_q  <= '0;
         word_left_q   <= '0;
         word_right_q  <= '0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_full_q   <= hold_full_d;
         hold_left_q   <= hold_left_d;
         hold_right_q  <= hold_right_d;
         word_left_q   <= word_left_d;
         word_right_q  <= word_right_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer against a frame-phase reference model.
module tb_i2s_tx_sequencer;

   localparam int WIDTH     = 24;
   localparam int SLOT      = 32;
   localparam int BCK_DIV   = 4;
   localparam int FRAME_CYC = 2 * SLOT * BCK_DIV;

   logic             scki = 1'b0;
   logic             rst;
   logic             enable;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_left;
   logic [WIDTH-1:0] s_right;
   logic             bck;
   logic             lrck;
   logic             sdata;
   logic             frame_start;
   logic             underrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   i2s_tx_sequencer #(
      .WIDTH   (WIDTH),
      .SLOT    (SLOT),
      .BCK_DIV (BCK_DIV)
   ) dut (
      .scki        (scki),
      .rst         (rst),
      .enable      (enable),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_left      (s_left),
      .s_right     (s_right),
      .bck         (bck),
      .lrck        (lrck),
      .sdata       (sdata),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 scki = ~scki;

   logic [5:0] dut_vec;
   assign dut_vec = {bck, lrck, sdata, frame_start, underrun, s_ready};

   // Reference model: frame phase n counts scki cycles since the frame load.
   bit                 m_on = 1'b0;
   bit                 m_stopping = 1'b0;
   int                 m_n = 0;
   logic [WIDTH-1:0]   m_l = '0;
   logic [WIDTH-1:0]   m_r = '0;
   logic               m_fs = 1'b0;
   logic               m_ur = 1'b0;
   logic               m_acc = 1'b0;
   logic [2*WIDTH-1:0] m_hold[$];
   logic [2*WIDTH-1:0] m_frames[$];
   logic [5:0]         exp_vec = 6'b000001;

   function automatic logic [5:0] model_outputs();
      int               bitn;
      int               b;
      logic [WIDTH-1:0] w;
      logic             eb, el, ed;
      eb = 1'b0; el = 1'b0; ed = 1'b0;
      if (m_on) begin
         eb   = (m_n % BCK_DIV) >= BCK_DIV / 2;
         bitn = m_n / BCK_DIV;
         el   = bitn >= SLOT;
         b    = bitn % SLOT;
         w    = el ? m_r : m_l;
         if (b >= 1 && b <= WIDTH) ed = w[WIDTH-b];
      end
      return {eb, el, ed, m_fs, m_ur, (m_hold.size() == 0)};
   endfunction

   // Apply one scki edge to the model (inputs as they stand) and to the DUT.
   task automatic clk_step();
      bit load;
      m_acc = s_valid && (m_hold.size() == 0);
      load  = 1'b0;
      m_fs  = 1'b0;
      m_ur  = 1'b0;
      if (!m_on) begin
         if (enable) begin m_on = 1'b1; m_n = 0; load = 1'b1; end
      end else if (m_n == FRAME_CYC - 1) begin
         m_n = 0;
         if (m_stopping && !enable) m_on = 1'b0;
         else load = 1'b1;
      end else begin
         m_n++;
      end
      m_stopping = m_on && !enable;
      if (load) begin
         m_fs = 1'b1;
         if (m_hold.size() != 0) begin
            {m_l, m_r} = m_hold.pop_front();
         end else begin
            m_l = '0; m_r = '0; m_ur = 1'b1;
         end
         m_frames.push_back({m_l, m_r});
      end
      if (m_acc) m_hold.push_back({s_left, s_right});
      @(posedge scki);
      #1;
      exp_vec = model_outputs();
      cyc++;
   endtask

   // Passive monitor: reassemble transmitted words from sdata sampled on bck rising.
   logic [WIDTH-1:0]   mon_l = '0, mon_r = '0, mon_sh = '0;
   int                 mon_idx = 0;
   logic               mon_lr = 1'b0;
   logic [2*WIDTH-1:0] mon_frames[$];

   initial forever begin
      @(posedge bck or posedge rst);
      if (rst) begin
         mon_idx = 0;
         mon_lr  = 1'b0;
      end else begin
         if (lrck !== mon_lr) begin mon_idx = 0; mon_lr = lrck; end
         if (mon_idx >= 1 && mon_idx <= WIDTH) mon_sh = {mon_sh[WIDTH-2:0], sdata};
         if (mon_idx == WIDTH) begin
            if (lrck) mon_r = mon_sh;
            else mon_l = mon_sh;
         end
         if (lrck && mon_idx == SLOT - 1) mon_frames.push_back({mon_l, mon_r});
         mon_idx++;
      end
   end

   task automatic test_reset();
      repeat (3) @(posedge scki);
      #1 rst = 1'b0;
      checks++;
      if (dut_vec !== 6'b000001) begin
         errors++; $display("FAIL reset_values got %b want %b", dut_vec, 6'b000001);
      end
      s_valid = 1'b1; s_left = WIDTH'($urandom); s_right = WIDTH'($urandom); enable = 1'b1;
      repeat (150) begin
         clk_step();
         s_valid = 1'b0;
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_prerun cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      // Asynchronous reset mid-frame takes effect without a clock edge
      #2 rst = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 6'b000001) begin
         errors++; $display("FAIL reset_async got %b want %b", dut_vec, 6'b000001);
      end
      enable = 1'b0;
      m_on = 1'b0; m_stopping = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
      m_hold.delete(); m_frames.delete(); mon_frames.delete();
      repeat (2) clk_step();
      rst = 1'b0;
      repeat (1000) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL reset_idle cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
   endtask

   task automatic test_single_frame();
      int fs_first, fs_second;
      logic [2*WIDTH-1:0] got, want;
      fs_first = -1; fs_second = -1;
      s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h5A5A5A;
      clk_step();
      s_valid = 1'b0; enable = 1'b1;
      repeat (2 * FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL single cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
         if (frame_start === 1'b1) begin
            if (fs_first < 0) fs_first = cyc;
            else if (fs_second < 0) fs_second = cyc;
         end
      end
      checks++;
      if (fs_second - fs_first != FRAME_CYC) begin
         errors++; $display("FAIL frame_period got %0d want %0d", fs_second - fs_first, FRAME_CYC);
      end
      checks++;
      if (mon_frames.size() == 0 || mon_frames[0] !== {24'hA5A5A5, 24'h5A5A5A}) begin
         errors++; $display("FAIL single_words got %h want %h",
                            (mon_frames.size() == 0) ? '0 : mon_frames[0], {24'hA5A5A5, 24'h5A5A5A});
      end
      enable = 1'b0;
      repeat (FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL single_stop cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      checks++;
      if (mon_frames.size() != m_frames.size()) begin
         errors++; $display("FAIL single_frame_count got %0d want %0d", mon_frames.size(), m_frames.size());
      end
      while (mon_frames.size() > 0 && m_frames.size() > 0) begin
         got = mon_frames.pop_front(); want = m_frames.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL single_frame got %h want %h", got, want); end
      end
      mon_frames.delete(); m_frames.delete();
   endtask

   task automatic test_underrun();
      int n_ur, n_tog;
      logic prev_lr;
      logic [2*WIDTH-1:0] got, want;
      n_ur = 0; n_tog = 0; prev_lr = 1'b0;
      enable = 1'b1; s_valid = 1'b0;
      repeat (3 * FRAME_CYC) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL underrun cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
         if (underrun === 1'b1) n_ur++;
         if (lrck !== prev_lr) n_tog++;
         prev_lr = lrck;
      end
      checks++;
      if (n_ur != 3) begin errors++; $display("FAIL underrun_pulses got %0d want 3", n_ur); end
      checks++;
      if (n_tog != 5) begin errors++; $display("FAIL lrck_toggles got %0d want 5", n_tog); end
      enable = 1'b0;
      repeat (FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL underrun_stop cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      while (mon_frames.size() > 0 && m_frames.size() > 0) begin
         got = mon_frames.pop_front(); want = m_frames.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL underrun_frame got %h want %h", got, want); end
      end
      mon_frames.delete(); m_frames.delete();
   endtask

   task automatic test_back_to_back();
      logic [2*WIDTH-1:0] pairs[3];
      logic [2*WIDTH-1:0] got, want;
      int acc[3];
      int idx, n;
      for (int k = 0; k < 3; k++) begin
         pairs[k] = {WIDTH'($urandom), WIDTH'($urandom)};
         acc[k]   = 0;
      end
      idx = 0;
      {s_left, s_right} = pairs[0]; s_valid = 1'b1; enable = 1'b1;
      repeat (4 * FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL b2b cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
         if (m_acc) begin
            acc[idx] = cyc; idx++;
            if (idx < 3) {s_left, s_right} = pairs[idx];
            else s_valid = 1'b0;
         end
      end
      enable = 1'b0;
      repeat (FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL b2b_stop cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      checks++;
      if (idx != 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", idx); end
      checks++;
      if (acc[2] - acc[1] != FRAME_CYC) begin
         errors++; $display("FAIL b2b_third_gap got %0d want %0d", acc[2] - acc[1], FRAME_CYC);
      end
      checks++;
      if (acc[1] - acc[0] > FRAME_CYC + 1 || acc[1] <= acc[0]) begin
         errors++; $display("FAIL b2b_second_gap got %0d want 1..%0d", acc[1] - acc[0], FRAME_CYC + 1);
      end
      for (int k = 0; k < 3; k++) begin
         n = 0;
         foreach (mon_frames[j]) if (mon_frames[j] === pairs[k]) n++;
         checks++;
         if (n != 1) begin errors++; $display("FAIL b2b_pair%0d_sent got %0d want 1", k, n); end
      end
      while (mon_frames.size() > 0 && m_frames.size() > 0) begin
         got = mon_frames.pop_front(); want = m_frames.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL b2b_frame got %h want %h", got, want); end
      end
      mon_frames.delete(); m_frames.delete();
   endtask

   task automatic test_enable_drop();
      logic [2*WIDTH-1:0] pa, pb, got, want;
      pa = {WIDTH'($urandom), WIDTH'($urandom)};
      pb = {WIDTH'($urandom), WIDTH'($urandom)};
      {s_left, s_right} = pa; s_valid = 1'b1;
      clk_step();
      {s_left, s_right} = pb; enable = 1'b1;
      // 41 edges from entry leaves bit_ctr at 10
      repeat (41) begin
         clk_step();
         if (m_acc) s_valid = 1'b0;
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL drop_run cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      enable = 1'b0;
      for (int k = 0; k < 400 && m_on; k++) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL drop_stop cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL drop_held got s_ready=%b want 0", s_ready); end
      repeat (50) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL drop_idle cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      enable = 1'b1;
      repeat (FRAME_CYC + 4) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL drop_rerun cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      enable = 1'b0;
      repeat (FRAME_CYC + 8) clk_step();
      checks++;
      if (mon_frames.size() < 2 || mon_frames[1] !== pb) begin
         errors++; $display("FAIL drop_held_sent got %h want %h",
                            (mon_frames.size() < 2) ? '0 : mon_frames[1], pb);
      end
      while (mon_frames.size() > 0 && m_frames.size() > 0) begin
         got = mon_frames.pop_front(); want = m_frames.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL drop_frame got %h want %h", got, want); end
      end
      mon_frames.delete(); m_frames.delete();
   endtask

   task automatic test_extreme();
      s_valid = 1'b1; s_left = 24'h800000; s_right = 24'h7FFFFF;
      clk_step();
      s_valid = 1'b0; enable = 1'b1;
      repeat (10) clk_step();
      enable = 1'b0;
      repeat (FRAME_CYC + 8) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL extreme cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      checks++;
      if (mon_frames.size() != 1 || mon_frames[0] !== {24'h800000, 24'h7FFFFF}) begin
         errors++; $display("FAIL extreme_words got %h (n=%0d) want %h",
                            (mon_frames.size() == 0) ? '0 : mon_frames[0], mon_frames.size(),
                            {24'h800000, 24'h7FFFFF});
      end
      mon_frames.delete(); m_frames.delete();
   endtask

   task automatic test_random();
      logic [2*WIDTH-1:0] got, want;
      enable = 1'b1;
      repeat (4000) begin
         s_valid = ($urandom_range(0, 3) == 0);
         s_left  = WIDTH'($urandom);
         s_right = WIDTH'($urandom);
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL random cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      enable = 1'b0; s_valid = 1'b0;
      repeat (FRAME_CYC + 40) begin
         clk_step();
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++; $display("FAIL random_stop cyc %0d got %b want %b", cyc, dut_vec, exp_vec);
         end
      end
      checks++;
      if (mon_frames.size() != m_frames.size()) begin
         errors++; $display("FAIL random_frame_count got %0d want %0d", mon_frames.size(), m_frames.size());
      end
      while (mon_frames.size() > 0 && m_frames.size() > 0) begin
         got = mon_frames.pop_front(); want = m_frames.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL random_frame got %h want %h", got, want); end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
      test_reset();
      test_single_frame();
      test_underrun();
      test_back_to_back();
      test_enable_drop();
      test_extreme();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
